rib_rr_arbiter: RTL and testbench
=================================

# rib_rr_arbiter

Round-robin bus arbiter with a strict-priority class. It shares one RIB-style slave port among `N_MASTER` requesters: the core data port, the core fetch port, the JTAG debug port and the UART download port. The arbiter grants one master per transaction and holds that grant until the slave returns ready or a timeout fires. It sits between the masters and the address decoder, and drives the core hold flag whenever a non-core master owns the bus.

## Interface
Parameters:
- `N_MASTER`, 4: number of requesters (2..8).
- `PRIO_MASK`, 4'b1100: masters in this set win over any master outside it.
- `CORE_MASK`, 4'b0011: masters belonging to the core; a grant to any other master raises `hold_o`.
- `TIMEOUT`, 255: BUSY cycles allowed before abort (1..65535).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `m_req_i` in N_MASTER: per-master request, held until that master's ready.
- `m_we_i` in N_MASTER: per-master write enable.
- `m_addr_i` in N_MASTER×MemAddrBus: per-master address.
- `m_data_i` in N_MASTER×MemBus: per-master write data.
- `m_data_o` out MemBus: read data, broadcast to all masters.
- `m_ready_o` out N_MASTER: one-hot, one-cycle completion strobe.
- `m_err_o` out N_MASTER: one-hot, set together with `m_ready_o` on timeout.
- `s_req_o` out 1: slave request.
- `s_we_o` out 1: slave write enable.
- `s_addr_o` out MemAddrBus: slave address.
- `s_data_o` out MemBus: slave write data.
- `s_data_i` in MemBus: slave read data.
- `s_ready_i` in 1: slave completion.
- `hold_o` out 1: a non-CORE_MASK master owns the bus.
- `grant_o` out log2(N_MASTER): index of the current owner, for debug.

## Operation
FSM states are IDLE and BUSY. Registered state: state, `grant_o`, round-robin pointer `ptr`, timeout counter `cnt`.

- **Reset:** state=IDLE, `ptr`=0, `grant_o`=0, `cnt`=0. All outputs are 0: `s_req_o`, `s_we_o`, `s_addr_o`, `s_data_o`, `m_ready_o`, `m_err_o`, `m_data_o`, `hold_o`.
- **Arbitration (IDLE, combinational):**
  - cand = `m_req_i & PRIO_MASK` if that is nonzero, else `m_req_i`.
  - Winner = first set bit of cand, searching from index `ptr` upward with wrap.
  - If cand≠0: `grant_o`←winner, `cnt`←0, go to BUSY.
- **BUSY:**
  - `s_req_o = m_req_i[grant_o]`.
  - `s_we_o`, `s_addr_o`, `s_data_o` are muxed combinationally from master `grant_o`.
  - `hold_o = ~CORE_MASK[grant_o]`.
- **Completion:** in BUSY, `s_ready_i`=1 with `s_req_o`=1 gives:
  - `m_ready_o[grant_o]`=1 and `m_data_o`=`s_data_i`, both in the same cycle.
  - `ptr`←(grant_o+1) mod N_MASTER, state←IDLE.
- **Timeout:** in BUSY, `cnt` increments every cycle without completion. When `cnt`==TIMEOUT-1 and `s_ready_i`=0:
  - `m_ready_o[grant_o]`=1, `m_err_o[grant_o]`=1, `m_data_o`=0.
  - `ptr` advances, state←IDLE.
  - `s_ready_i` in the same cycle as the timeout takes precedence: normal completion, no error.
- **Abandon:** the granted master drops `m_req_i` while BUSY.
  - `s_req_o` falls in the same cycle.
  - state←IDLE next edge, no `m_ready_o`, `ptr` advances.
- **Idle outputs:** outside BUSY, `m_data_o`=0, `s_req_o`=0 and `hold_o`=0. `s_addr_o`, `s_data_o` and `s_we_o` are 0 in IDLE.
- **Reset mid-transaction:** immediate return to the reset state. No ready is issued.
- **Write requests:** `m_data_o` is don't-care but is still driven from `s_data_i`.

## Timing
- Request sampled in IDLE at edge k → `s_req_o` high in cycle k+1.
- A combinational slave (`s_ready_i`=1 in its first cycle) gives `m_ready_o` in cycle k+1. Minimum latency is 1 cycle after the grant edge.
- One IDLE cycle separates consecutive transactions, so throughput is at most one transaction per 2 cycles.
- A timeout completes exactly TIMEOUT cycles after BUSY entry.
- `m_ready_o`, `m_err_o`, `m_data_o` and `s_*` are combinational from state and inputs. There is no combinational path from `s_ready_i` to `s_req_o`.
- The grant never changes while BUSY.

## Test plan
- **Single master:** reset; master 0 reads addr 0x1000_0004, slave ready on first BUSY cycle with data 0xA5A5_0001.
  - `m_ready_o`=4'b0001 one cycle after the grant edge, `m_data_o`=0xA5A5_0001, `hold_o`=0 throughout.
- **Round robin:** masters 0 and 1 request continuously, slave always ready.
  - Grants alternate 0,1,0,1.
  - `m_ready_o` pulses every 2 cycles.
- **Priority:** masters 0, 1 and 3 request together.
  - Master 3 is granted first and `hold_o`=1 during its BUSY.
  - Then master 0, then master 1.
  - Master 2 requesting while 3 is busy is granted before 0.
- **Timeout:** TIMEOUT=4; slave never ready on a master 2 write.
  - `m_ready_o[2]`=1 and `m_err_o[2]`=1 in the 4th BUSY cycle, `m_data_o`=0.
  - Next grant goes to the next requester.
- **Simultaneous:** `s_ready_i`=1 exactly in the timeout cycle.
  - `m_err_o`=0 and `m_data_o`=`s_data_i`.
- **Abandon and reset:**
  - Master 1 drops `m_req_i` after 2 BUSY cycles → `s_req_o`=0 that cycle, no `m_ready_o`, IDLE next.
  - Assert `rst_ni`=0 mid-BUSY → all outputs 0 immediately, `ptr`=0.

Source files
------------

// File: rtl/rib_rr_arbiter.sv
// rtl/rib_rr_arbiter.sv - round-robin RIB bus arbiter with a strict-priority master class
// One transaction per grant. The grant holds until slave ready, timeout or the master drops its request.

module rib_rr_arbiter #(
    parameter int                    N_MASTER  = 4,
    parameter logic [N_MASTER-1:0]   PRIO_MASK = 4'b1100,
    parameter logic [N_MASTER-1:0]   CORE_MASK = 4'b0011,
    parameter int                    TIMEOUT   = 255,
    parameter int                    ADDR_W    = 32,
    parameter int                    DATA_W    = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [N_MASTER-1:0]                m_req_i,
    input  logic [N_MASTER-1:0]                m_we_i,
    input  logic [N_MASTER-1:0][ADDR_W-1:0]    m_addr_i,
    input  logic [N_MASTER-1:0][DATA_W-1:0]    m_data_i,
    output logic [DATA_W-1:0]                  m_data_o,
    output logic [N_MASTER-1:0]                m_ready_o,
    output logic [N_MASTER-1:0]                m_err_o,
    output logic                               s_req_o,
    output logic                               s_we_o,
    output logic [ADDR_W-1:0]                  s_addr_o,
    output logic [DATA_W-1:0]                  s_data_o,
    input  logic [DATA_W-1:0]                  s_data_i,
    input  logic                               s_ready_i,
    output logic                               hold_o,
    output logic [$clog2(N_MASTER)-1:0]        grant_o
);

    localparam int GW = $clog2(N_MASTER);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [N_MASTER-1:0] prio_req;
    logic [N_MASTER-1:0] cand;
    logic [GW-1:0]       winner;
    logic                found;
    logic [GW:0]         idx;
    logic [GW-1:0]       ptr_next;

    // Rotating first-set search over the candidate set, starting at ptr.
    always_comb begin
        prio_req = m_req_i & PRIO_MASK;
        cand     = (prio_req != '0) ? prio_req : m_req_i;
        winner   = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            idx = {1'b0, ptr_q} + (GW+1)'(i);
            if (idx >= (GW+1)'(N_MASTER)) begin
                idx = idx - (GW+1)'(N_MASTER);
            end
            if (!found && cand[idx[GW-1:0]]) begin
                found  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        if (grant_q == GW'(N_MASTER - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_q + GW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        s_req_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m_data_o  = '0;
        m_ready_o = '0;
        m_err_o   = '0;
        hold_o    = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_req_o  = m_req_i[grant_q];
                s_we_o   = m_we_i[grant_q];
                s_addr_o = m_addr_i[grant_q];
                s_data_o = m_data_i[grant_q];
                hold_o   = ~CORE_MASK[grant_q];
                // Slave ready outranks the timeout when both land in the same cycle.
                if (!m_req_i[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = ptr_next;
                end else if (s_ready_i) begin
                    m_ready_o[grant_q] = 1'b1;
                    m_data_o           = s_data_i;
                    state_d            = IDLE;
                    ptr_d              = ptr_next;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    m_ready_o[grant_q] = 1'b1;
                    m_err_o[grant_q]   = 1'b1;
                    state_d            = IDLE;
                    ptr_d              = ptr_next;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o = grant_q;

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// tb/tb_rib_rr_arbiter.sv - directed and randomized bench for rib_rr_arbiter against a transaction-level model

module tb_rib_rr_arbiter;

    localparam int         NM      = 4;
    localparam int         TMO     = 4;
    localparam logic [3:0] PRIO    = 4'b1100;
    localparam logic [3:0] CORE    = 4'b0011;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [3:0]        m_req;
    logic [3:0]        m_we;
    logic [3:0][31:0]  m_addr;
    logic [3:0][31:0]  m_wdata;
    logic [31:0]       m_rdata;
    logic [3:0]        m_ready;
    logic [3:0]        m_err;
    logic              s_req;
    logic              s_we;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [31:0]       s_rdata;
    logic              s_ready;
    logic              hold;
    logic [1:0]        grant;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;
    int won;

    rib_rr_arbiter #(
        .N_MASTER  (NM),
        .PRIO_MASK (PRIO),
        .CORE_MASK (CORE),
        .TIMEOUT   (TMO),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .m_req_i   (m_req),
        .m_we_i    (m_we),
        .m_addr_i  (m_addr),
        .m_data_i  (m_wdata),
        .m_data_o  (m_rdata),
        .m_ready_o (m_ready),
        .m_err_o   (m_err),
        .s_req_o   (s_req),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_data_o  (s_wdata),
        .s_data_i  (s_rdata),
        .s_ready_i (s_ready),
        .hold_o    (hold),
        .grant_o   (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Priority class first, then the first requester at or after the pointer.
    function automatic int model_winner(input logic [3:0] req, input int p);
        logic [3:0] c;
        c = ((req & PRIO) != 4'b0) ? (req & PRIO) : req;
        for (int k = 0; k < NM; k++) begin
            if (c[(p + k) % NM]) return (p + k) % NM;
        end
        return -1;
    endfunction

    task automatic chk_quiet(input string tag, input logic [1:0] exp_grant);
        chk({tag, "_ctl"}, 64'({s_req, s_we, hold}), 64'd0);
        chk({tag, "_rdy"}, 64'({m_ready, m_err}), 64'd0);
        chk({tag, "_bus"}, {s_addr, s_wdata}, 64'd0);
        chk({tag, "_mdata"}, 64'(m_rdata), 64'd0);
        chk({tag, "_grant"}, 64'(grant), 64'(exp_grant));
    endtask

    // One IDLE arbitration cycle followed by the BUSY phase until it ends.
    task automatic txn(input logic [3:0] req, input int lat, input int ab, input int rst_at,
                       input bit directed, output int w);
        logic [3:0] onehot;
        bit         fin;
        @(negedge clk);
        m_req = req;
        s_ready = 1'b0;
        s_rdata = $urandom;
        for (int i = 0; i < NM; i++) begin
            m_we[i]    = 1'($urandom);
            m_addr[i]  = $urandom;
            m_wdata[i] = $urandom;
        end
        if (directed) begin
            m_we      = 4'b0100;
            m_addr[0] = 32'h1000_0004;
        end
        #1;
        chk("idle_ctl", 64'({s_req, s_we, hold}), 64'd0);
        chk("idle_rdy", 64'({m_ready, m_err}), 64'd0);
        chk("idle_bus", {s_addr, s_wdata}, 64'd0);
        w = model_winner(req, ptr_m);
        if (w < 0) return;
        onehot = 4'b0001 << w;
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            fin = 1'b0;
            if (c == rst_at) begin
                rst_ni = 1'b0;
                #1;
                chk_quiet("rst_mid", 2'd0);
                ptr_m = 0;
                @(negedge clk);
                rst_ni = 1'b1;
                m_req  = 4'b0;
                return;
            end
            if (c == ab) m_req[w] = 1'b0;
            s_ready = (c == lat);
            s_rdata = directed ? 32'hA5A5_0001 : $urandom;
            #1;
            chk("grant", 64'(grant), 64'(w));
            chk("hold", 64'(hold), 64'(!CORE[w]));
            chk("s_addr", 64'(s_addr), 64'(m_addr[w]));
            chk("s_wdata", 64'({s_we, s_wdata}), 64'({m_we[w], m_wdata[w]}));
            if (c == ab) begin
                chk("abandon_sreq", 64'(s_req), 64'd0);
                chk("abandon_rdy", 64'({m_ready, m_err}), 64'd0);
                fin = 1'b1;
            end else begin
                chk("s_req", 64'(s_req), 64'd1);
                if (c == lat) begin
                    chk("done_rdy", 64'({m_ready, m_err}), 64'({onehot, 4'b0}));
                    chk("done_data", 64'(m_rdata), 64'(s_rdata));
                    fin = 1'b1;
                end else if (c == TMO - 1) begin
                    chk("tmo_rdy", 64'({m_ready, m_err}), 64'({onehot, onehot}));
                    chk("tmo_data", 64'(m_rdata), 64'd0);
                    fin = 1'b1;
                end else begin
                    chk("wait_rdy", 64'({m_ready, m_err}), 64'd0);
                end
            end
            if (fin) begin
                ptr_m = (w + 1) % NM;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni  = 1'b0;
        m_req   = 4'b0;
        s_ready = 1'b0;
        s_rdata = 32'hFFFF_FFFF;
        #1;
        chk_quiet("reset", 2'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        ptr_m  = 0;
    endtask

    initial begin
        int exp_rr[4];
        rst_ni  = 1'b0;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        s_rdata = '0;
        s_ready = 1'b0;
        do_reset();

        txn(4'b0001, 0, -1, -1, 1'b1, won);
        chk("single_won", 64'(won), 64'd0);

        do_reset();
        exp_rr = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            txn(4'b0011, 0, -1, -1, 1'b0, won);
            chk("rr_won", 64'(won), 64'(exp_rr[i]));
        end

        txn(4'b1011, 1, -1, -1, 1'b0, won);
        chk("prio_first", 64'(won), 64'd3);
        txn(4'b0011, 0, -1, -1, 1'b0, won);
        chk("prio_then0", 64'(won), 64'd0);
        txn(4'b0010, 0, -1, -1, 1'b0, won);
        chk("prio_then1", 64'(won), 64'd1);
        txn(4'b1001, 2, -1, -1, 1'b0, won);
        chk("prio_m3", 64'(won), 64'd3);
        txn(4'b0101, 0, -1, -1, 1'b0, won);
        chk("prio_m2_before_0", 64'(won), 64'd2);
        txn(4'b0001, 0, -1, -1, 1'b0, won);

        txn(4'b0100, 99, -1, -1, 1'b1, won);
        chk("tmo_won", 64'(won), 64'd2);
        txn(4'b0011, 0, -1, -1, 1'b0, won);
        chk("tmo_next", 64'(won), 64'd0);

        txn(4'b0010, TMO - 1, -1, -1, 1'b0, won);
        chk("simul_won", 64'(won), 64'd1);

        txn(4'b0010, 99, 2, -1, 1'b0, won);
        chk("abandon_won", 64'(won), 64'd1);

        txn(4'b0001, 0, -1, -1, 1'b0, won);
        txn(4'b0100, 99, -1, 1, 1'b0, won);
        txn(4'b0011, 0, -1, -1, 1'b0, won);
        chk("post_reset_ptr", 64'(won), 64'd0);

        for (int n = 0; n < 300; n++) begin
            int ab;
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            txn(4'($urandom_range(0, 15)), int'($urandom_range(0, 5)), ab, -1, 1'b0, won);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
